// File: rtl/arb_pkg.sv
// +----------------------------------------------------------------------+
// | arb_pkg: controller state codes and FSM encoding for arbiter_rr_4to1 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  localparam int DEFAULT_DATA_WIDTH = 6;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arbiter_rr_4to1_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick4: first set request at or after ptr, searching modulo 4      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick4 (
  input  logic [1:0] ptr,
  input  logic [3:0] req,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] w_cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    idx    = ptr;
    w_cand = ptr;
    for (int k = 3; k >= 0; k--) begin
      w_cand = ptr + 2'(k);
      if (req[w_cand]) idx = w_cand;
    end
  end

  assign any = |req;

endmodule

`default_nettype wire

// File: rtl/arbiter_rr_4to1.sv
// +----------------------------------------------------------------------+
// | arbiter_rr_4to1: round-robin burst arbiter, four FWFT FIFOs into one |
// | Optional ARB_GRANT_CNT_EN adds per-requester pop counters. Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module arbiter_rr_4to1
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BURST      = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [3:0]            state,
  input  logic                  empty0,
  input  logic                  empty1,
  input  logic                  empty2,
  input  logic                  empty3,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  almost_full,
  output logic                  pop0,
  output logic                  pop1,
  output logic                  pop2,
  output logic                  pop3,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
`ifdef ARB_GRANT_CNT_EN
  output logic [7:0]            cnt0,
  output logic [7:0]            cnt1,
  output logic [7:0]            cnt2,
  output logic [7:0]            cnt3,
`endif
  output logic [1:0]            grant
);

  localparam int                CNT_W       = $clog2(BURST + 1);
  localparam logic [CNT_W-1:0]  c_burst_max = CNT_W'(BURST);

  arb_state_t            r_state, w_state_next;
  logic [1:0]            r_ptr, w_ptr_next;
  logic [1:0]            r_grant, w_grant_next;
  logic [CNT_W-1:0]      r_burst_cnt, w_cnt_next;
  logic [1:0]            w_pick_idx, w_pop_idx;
  logic                  w_pick_any, w_enabled, w_pop_any, w_pop_fire;
  logic [3:0]            w_empty, w_req, w_pop_vec;
  logic [DATA_WIDTH-1:0] w_data_in [4];
  logic                  r_push;
  logic [DATA_WIDTH-1:0] r_data_out;

  assign w_empty      = {empty3, empty2, empty1, empty0};
  assign w_req        = ~w_empty;
  assign w_data_in[0] = data_in0;
  assign w_data_in[1] = data_in1;
  assign w_data_in[2] = data_in2;
  assign w_data_in[3] = data_in3;
  assign w_enabled    = (state == ST_IDLE) || (state == ST_ACTIVE);

  rr_pick4 u_pick (
    .ptr (r_ptr),
    .req (w_req),
    .idx (w_pick_idx),
    .any (w_pick_any)
  );

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_grant_next = r_grant;
    w_cnt_next   = r_burst_cnt;
    w_pop_any    = 1'b0;
    w_pop_idx    = r_grant;
    if (!w_enabled) begin
      w_state_next = ARB_IDLE;
      if (r_state == ARB_BURST) w_ptr_next = r_grant + 2'd1;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (!almost_full && w_pick_any) begin
            w_pop_any    = 1'b1;
            w_pop_idx    = w_pick_idx;
            w_grant_next = w_pick_idx;
            w_cnt_next   = CNT_W'(1);
            w_state_next = ARB_BURST;
          end
        end
        ARB_BURST: begin
          // Backpressure pauses the burst with the count held.
          if (!almost_full) begin
            if (r_burst_cnt == c_burst_max || w_empty[r_grant]) begin
              w_state_next = ARB_IDLE;
              w_ptr_next   = r_grant + 2'd1;
            end else begin
              w_pop_any  = 1'b1;
              w_cnt_next = r_burst_cnt + 1'b1;
            end
          end
        end
        default: w_state_next = ARB_IDLE;
      endcase
    end
  end

  // Pops are combinational, so hold them off while reset is asserted.
  assign w_pop_fire = w_pop_any & reset_L;

  always_comb begin
    w_pop_vec = 4'b0000;
    if (w_pop_fire) w_pop_vec[w_pop_idx] = 1'b1;
  end

  assign {pop3, pop2, pop1, pop0} = w_pop_vec;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= 2'd0;
      r_grant     <= 2'd0;
      r_burst_cnt <= '0;
      r_push      <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_grant     <= w_grant_next;
      r_burst_cnt <= w_cnt_next;
      r_push      <= w_pop_fire;
      if (w_pop_fire) r_data_out <= w_data_in[w_pop_idx];
    end
  end

  assign push     = r_push;
  assign data_out = r_data_out;
  assign grant    = r_grant;

`ifdef ARB_GRANT_CNT_EN
  logic [7:0] r_cnt [4];

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= 8'd0;
    end else if (state == ST_INIT) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= 8'd0;
    end else if (w_pop_fire) begin
      r_cnt[w_pop_idx] <= r_cnt[w_pop_idx] + 8'd1;
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];
`endif

endmodule

`default_nettype wire

// File: tb/tb_arbiter_rr_4to1.sv
// +----------------------------------------------------------------------+
// | tb_arbiter_rr_4to1: directed bench, BURST=4 and BURST=2 instances    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_arbiter_rr_4to1;
  import arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [3:0] state;
  logic       almost_full;

  logic [5:0] mem [2][4][256];
  logic [7:0] rd  [2][4] = '{default: 8'd0};
  logic [7:0] wr  [2][4] = '{default: 8'd0};
  logic       emp   [2][4];
  logic [5:0] din   [2][4];
  logic       popw  [2][4];
  logic       pushw [2];
  logic [5:0] doutw [2];
  logic [1:0] gntw  [2];
`ifdef ARB_GRANT_CNT_EN
  logic [7:0] cntw  [2][4];
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] tr_pop  [64];
  logic       tr_push [64];
  logic [5:0] tr_data [64];
  logic [1:0] tr_gnt  [64];
  int         exp_pop [$];
  int         exp_data[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    for (genvar i = 0; i < 4; i++) begin : g_fifo
      assign emp[g][i] = (rd[g][i] == wr[g][i]);
      assign din[g][i] = mem[g][i][rd[g][i]];
    end
    arbiter_rr_4to1 #(.DATA_WIDTH(6), .BURST((g == 0) ? 4 : 2)) u_dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .state       (state),
      .empty0      (emp[g][0]),
      .empty1      (emp[g][1]),
      .empty2      (emp[g][2]),
      .empty3      (emp[g][3]),
      .data_in0    (din[g][0]),
      .data_in1    (din[g][1]),
      .data_in2    (din[g][2]),
      .data_in3    (din[g][3]),
      .almost_full (almost_full),
      .pop0        (popw[g][0]),
      .pop1        (popw[g][1]),
      .pop2        (popw[g][2]),
      .pop3        (popw[g][3]),
      .push        (pushw[g]),
      .data_out    (doutw[g]),
`ifdef ARB_GRANT_CNT_EN
      .cnt0        (cntw[g][0]),
      .cnt1        (cntw[g][1]),
      .cnt2        (cntw[g][2]),
      .cnt3        (cntw[g][3]),
`endif
      .grant       (gntw[g])
    );
  end

  // Upstream FWFT FIFO models: head advances on the edge that sees pop.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 4; i++)
        if (popw[d][i]) rd[d][i] <= rd[d][i] + 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  task automatic load(input int d, input int i, input int val);
    mem[d][i][wr[d][i]] = 6'(val);
    wr[d][i] = wr[d][i] + 8'd1;
  endtask

  function automatic logic [3:0] popv(input int d);
    return {popw[d][3], popw[d][2], popw[d][1], popw[d][0]};
  endfunction

  function automatic int oh_idx(input int oh);
    case (oh)
      2: return 1;
      4: return 2;
      8: return 3;
      default: return 0;
    endcase
  endfunction

  // One nibble per cycle, first cycle in the most significant nibble.
  task automatic add_pops(input logic [63:0] hex, input int n);
    for (int k = 0; k < n; k++) exp_pop.push_back(int'(hex[4*(n-1-k) +: 4]));
  endtask

  task automatic run(input int d, input int n, input logic [31:0] af);
    for (int k = 0; k < n; k++) begin
      almost_full = af[k];
      #1;
      tr_pop[k] = popv(d);
      @(posedge clk);
      #1;
      tr_push[k] = pushw[d];
      tr_data[k] = doutw[d];
      tr_gnt[k]  = gntw[d];
    end
    almost_full = 1'b0;
  endtask

  task automatic check_trace(input string tag, input int n);
    int ep;
    for (int k = 0; k < n; k++) begin
      ep = exp_pop.pop_front();
      chk({tag, "_pop"}, 32'(tr_pop[k]), 32'(ep));
      if (ep != 0) begin
        chk({tag, "_push"}, 32'(tr_push[k]), 32'd1);
        chk({tag, "_data"}, 32'(tr_data[k]), 32'(exp_data.pop_front()));
        chk({tag, "_grant"}, 32'(tr_gnt[k]), 32'(oh_idx(ep)));
      end else begin
        chk({tag, "_nopush"}, 32'(tr_push[k]), 32'd0);
      end
    end
  endtask

  initial begin
    reset_L     = 1'b0;
    state       = ST_ACTIVE;
    almost_full = 1'b0;
    load(0, 0, 5);
    load(0, 1, 17);
    load(0, 2, 33);
    load(0, 3, 49);
    #2;
    chk("rst_pop", 32'(popv(0)), 32'd0);
    chk("rst_push", 32'(pushw[0]), 32'd0);
    chk("rst_data", 32'(doutw[0]), 32'd0);
    chk("rst_grant", 32'(gntw[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_pop_edge", 32'(popv(0)), 32'd0);
    chk("rst_push_edge", 32'(pushw[0]), 32'd0);

    // Released in ST_RESET: non-empty FIFOs must not be drained.
    state   = ST_RESET;
    reset_L = 1'b1;
    run(0, 5, 32'd0);
    for (int k = 0; k < 5; k++) begin
      chk("gate_pop", 32'(tr_pop[k]), 32'd0);
      chk("gate_push", 32'(tr_push[k]), 32'd0);
    end

    // One word per FIFO: round robin with a bubble after each word.
    state = ST_ACTIVE;
    add_pops(64'h10204080, 8);
    exp_data = '{5, 17, 33, 49};
    run(0, 8, 32'd0);
    check_trace("enable", 8);

    // FIFO1 alone with 6 words: 4-word burst, bubble, 2 more.
    for (int j = 0; j < 6; j++) load(0, 1, 10 + j);
    add_pops(64'h22220220, 8);
    exp_data = '{10, 11, 12, 13, 14, 15};
    run(0, 8, 32'd0);
    check_trace("burst", 8);

    // ptr=2: FIFO2 ends on empty after one word, FIFO3 then drains 3.
    load(0, 2, 30);
    for (int j = 0; j < 3; j++) load(0, 3, 40 + j);
    add_pops(64'h408880, 6);
    exp_data = '{30, 40, 41, 42};
    run(0, 6, 32'd0);
    check_trace("empty_end", 6);

    // ptr must now be 0, so FIFO1 is served ahead of FIFO3.
    load(0, 1, 50);
    load(0, 3, 51);
    add_pops(64'h2080, 4);
    exp_data = '{50, 51};
    run(0, 4, 32'd0);
    check_trace("ptr_wrap", 4);

    // almost_full for cycles 2..4 of a burst; count resumes at 2 of 4.
    for (int j = 0; j < 6; j++) load(0, 2, 20 + j);
    add_pops(64'h44000440440, 11);
    exp_data = '{20, 21, 22, 23, 24, 25};
    run(0, 11, 32'h1C);
    check_trace("bkpr", 11);

    // BURST=2 instance, all four FIFOs full of 8 words.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) load(1, i, i * 16 + j);
    for (int c = 0; c < 48; c++) begin
      if (c % 3 < 2) begin
        exp_pop.push_back(1 << ((c / 3) % 4));
        exp_data.push_back(((c / 3) % 4) * 16 + 2 * (c / 12) + (c % 3));
      end else begin
        exp_pop.push_back(0);
      end
    end
    run(1, 48, 32'd0);
    check_trace("fair", 48);

`ifdef ARB_GRANT_CNT_EN
    for (int i = 0; i < 4; i++) chk("cnt_after_fair", 32'(cntw[1][i]), 32'd8);
    state = ST_INIT;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("cnt_init_clear", 32'(cntw[1][i]), 32'd0);
    state = ST_ACTIVE;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
